// File: rtl/mem_access_unit.sv
// Memory-side stage of the multicycle MIPS datapath: runs one load/store transaction
// against a fixed-latency synchronous RAM, with sub-word stores done as read-modify-write.
`timescale 1ns/1ps

// state   | meaning
// IDLE    | waiting for start; mem_addr/mem_wdata/rdata hold
// RD_WAIT | read issued, counting edges until mem_rdata is valid
// WR      | single-cycle RAM write
// DONE    | one-cycle completion pulse, err valid
module mem_access_unit #(
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sign_ext_q, sign_ext_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [15:0] wdata_q, wdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        req_half, req_byte, req_misaligned;
    logic        lat_half, lat_byte;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;
    logic [31:0] merged;

    // size 11 is decoded as word: anything not half/byte is a word access
    assign req_half       = (size == 2'b01);
    assign req_byte       = (size == 2'b10);
    assign req_misaligned = req_half ? addr[0] : (!req_byte && (addr[1:0] != 2'b00));
    assign lat_half       = (size_q == 2'b01);
    assign lat_byte       = (size_q == 2'b10);

    always_comb begin
        rd_byte = mem_rdata[7:0];
        case (addr_lo_q)
            2'd0: rd_byte = mem_rdata[7:0];
            2'd1: rd_byte = mem_rdata[15:8];
            2'd2: rd_byte = mem_rdata[23:16];
            2'd3: rd_byte = mem_rdata[31:24];
            default: rd_byte = mem_rdata[7:0];
        endcase
        rd_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        load_val = mem_rdata;
        if (lat_byte)
            load_val = {{24{sign_ext_q & rd_byte[7]}}, rd_byte};
        else if (lat_half)
            load_val = {{16{sign_ext_q & rd_half[15]}}, rd_half};

        merged = mem_rdata;
        if (lat_byte) begin
            case (addr_lo_q)
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
                default: merged = mem_rdata;
            endcase
        end else if (addr_lo_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        size_d      = size_q;
        sign_ext_d  = sign_ext_q;
        addr_lo_d   = addr_lo_q;
        wdata_d     = wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    we_d       = we;
                    size_d     = size;
                    sign_ext_d = sign_ext;
                    addr_lo_d  = addr[1:0];
                    wdata_d    = wdata[15:0];
                    mem_addr_d = {addr[31:2], 2'b00};
                    if (req_misaligned) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (we && !req_half && !req_byte) begin
                        mem_wdata_d = wdata;
                        state_d     = WR;
                    end else begin
                        cnt_d   = 4'd1;
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == 4'(READ_LATENCY)) begin
                    if (we_q) begin
                        mem_wdata_d = merged;
                        state_d     = WR;
                    end else begin
                        rdata_d = load_val;
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WR: state_d = DONE;
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            sign_ext_q  <= 1'b0;
            addr_lo_q   <= 2'b00;
            wdata_q     <= 16'h0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            sign_ext_q  <= sign_ext_d;
            addr_lo_q   <= addr_lo_d;
            wdata_q     <= wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign mem_wr    = (state_q == WR);
    assign busy      = (state_q == RD_WAIT) || (state_q == WR);
    assign done      = (state_q == DONE);

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-side stage directly downstream of the address-select mux in the multicycle MIPS datapath.
- Takes the selected 32-bit address (PC, ALUResult, ALUOut or the jump/branch path) plus store data, and runs a complete memory transaction against a fixed-latency synchronous RAM.
- Supports word, halfword and byte loads (sign- or zero-extended) and stores. Sub-word stores use read-modify-write.
- Returns the load result as the MDR value, with a one-cycle done pulse to the control FSM.

Parameters:
READ_LATENCY, 2, edges from address presentation to valid mem_rdata; legal range 1..15 (4-bit counter).

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  synchronous, active-low reset
start  input  1  request strobe; sampled only in IDLE
we  input  1  1 = store, 0 = load
size  input  2  00 word, 01 halfword, 10 byte, 11 reserved (treated as word)
sign_ext  input  1  loads only: 1 = sign-extend sub-word, 0 = zero-extend
addr  input  32  byte address from the address-select mux
wdata  input  32  store data; halfword/byte taken from low bits
mem_rdata  input  32  RAM read data
mem_addr  output  32  word-aligned RAM address
mem_wr  output  1  RAM write enable
mem_wdata  output  32  RAM write data
rdata  output  32  load result (MDR)
busy  output  1  high in RD_WAIT and WR
done  output  1  one-cycle completion pulse
err  output  1  misalignment flag, valid with done

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-low (reset==0 at a rising edge).
- Reset values: state IDLE, all outputs 0, all latched request fields 0, counter 0.
- Reset mid-transaction: forces IDLE at the next edge. No write is issued afterwards and no done pulse is produced.
- Timing convention: edge 0 is the edge that samples start; "after edge n" means the value held until edge n+1.
- Endianness is little-endian.
  - byte offset k = addr[1:0] selects bits 8k+7:8k.
  - half offset addr[1]=0 selects bits 15:0; addr[1]=1 selects bits 31:16.
- Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0.

State machine (IDLE, RD_WAIT, WR, DONE):
- IDLE
  - start=1: latch addr, we, size, sign_ext, wdata.
  - mem_addr <= {addr[31:2],2'b00}.
  - Misaligned -> DONE with err=1; no RAM access.
  - Word store -> WR.
  - Any load, or sub-word store -> RD_WAIT with cnt=1.
- RD_WAIT
  - busy=1, mem_wr=0.
  - cnt increments each edge. At the edge where cnt==READ_LATENCY, mem_rdata is sampled.
  - Load: rdata <= extracted and extended value; -> DONE.
  - Sub-word store: mem_wdata <= sampled word with only the target lane(s) replaced by wdata low bits; -> WR.
- WR
  - busy=1, mem_wr=1 for exactly this cycle.
  - mem_wdata = wdata for word stores, merged word for sub-word stores; mem_addr unchanged.
  - -> DONE.
- DONE
  - done=1 and busy=0 for exactly one cycle; err holds its flag.
  - -> IDLE; err clears on leaving DONE.

Completion latency (done high after edge shown):
- Misaligned: edge 0.
- Word store: edge 1.
- Load: edge READ_LATENCY.
- Sub-word store: edge READ_LATENCY+1.

Other rules:
- start outside IDLE is ignored; nothing is queued.
- start in DONE is also ignored.
- rdata changes only on load completion; it holds across stores, errors and idle.
- mem_addr and mem_wdata hold their last values while idle.
- size 11 behaves as size 00.
- sign_ext is ignored for word loads and for stores.

Test Plan:
1. Load word: start, we=0, size=00, addr=0x0000_0010, mem_rdata=0xDEADBEEF at edge 2 -> mem_addr=0x10; done=1, rdata=0xDEADBEEF, err=0 after edge 2; mem_wr never 1.
2. Load byte: addr=0x13, mem_rdata=0x80FF_1234.
   - sign_ext=1 -> rdata=0xFFFF_FF80.
   - sign_ext=0 -> rdata=0x0000_0080.
   - Same test, size=01 at addr=0x12 -> rdata=0xFFFF_80FF (signed).
3. Store halfword: addr=0x22, wdata=0x0000_ABCD, mem_rdata=0x1122_3344 -> mem_wr=1 only between edges 2 and 3; mem_addr=0x20, mem_wdata=0xABCD_3344; done after edge 3.
4. Store word: addr=0x4, wdata=0xCAFEBABE -> mem_wr=1 after edge 0, mem_wdata=0xCAFEBABE; done after edge 1; no read wait.
5. Misaligned: load word at addr=0x6 -> done=1, err=1 after edge 0; mem_wr stays 0; rdata keeps its previous value. Repeat with halfword store at 0x3 -> same result.
6. Reset and ignored start:
   - reset=0 during RD_WAIT of a sub-word store -> IDLE after next edge, busy=0, done never pulses, mem_wr stays 0.
   - A second start asserted while busy -> ignored; exactly one done per accepted request.
